// File: rtl/e203_ifu_rsp2ir.sv
// IFU response-to-IR stage: tracks outstanding fetch PCs in order, drops stale
// responses after a flush, and registers IR/PC for decode.
// Optional zero-latency response bypass: define E203_IFU_RSP2IR_BYPASS_EN.
`ifndef E203_PC_SIZE
`define E203_PC_SIZE 32
`endif

module e203_ifu_rsp2ir #(
  parameter int OUTS_DEPTH = 2,
  parameter int CNT_W      = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ifu_req_valid,
  input  logic                     ifu_req_ready,
  input  logic [`E203_PC_SIZE-1:0] ifu_req_pc,
  output logic                     req_allow,
  input  logic                     ifu_rsp_valid,
  output logic                     ifu_rsp_ready,
  input  logic                     ifu_rsp_err,
  input  logic [31:0]              ifu_rsp_instr,
  input  logic                     pipe_flush,
  output logic                     ir_valid,
  input  logic                     ir_ready,
  output logic [31:0]              ir_instr,
  output logic [`E203_PC_SIZE-1:0] ir_pc,
  output logic                     ir_err,
  output logic                     ir_rv32
);
  localparam int PCW = `E203_PC_SIZE;
  localparam int PW  = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;

  typedef struct packed {
    logic [31:0]    instr;
    logic [PCW-1:0] pc;
    logic           err;
    logic           rv32;
  } ir_t;

  logic [OUTS_DEPTH-1:0][PCW-1:0] pcq;
  logic [PW-1:0]    wptr, rptr;
  logic [CNT_W-1:0] out_cnt, drop_cnt;
  logic             ir_valid_r;
  ir_t              ir_r, rsp_ir, ir_out;
  logic             full, empty, stale;
  logic             req_fire, rsp_fire, push, pop, load, ld_reg;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTS_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (out_cnt == CNT_W'(OUTS_DEPTH));
  assign empty    = (out_cnt == '0);
  assign stale    = (drop_cnt != '0);
  assign req_fire = ifu_req_valid & ifu_req_ready;
  assign rsp_fire = ifu_rsp_valid & ifu_rsp_ready;
  // A pop frees a slot in the same cycle, so push-while-full is legal then.
  assign pop      = rsp_fire & ~empty;
  assign push     = req_fire & (~full | pop);
  assign load     = pop & ~stale & ~pipe_flush;

  assign req_allow     = ~full;
  assign ifu_rsp_ready = stale | ~ir_valid_r | ir_ready | pipe_flush;

  assign rsp_ir = '{instr: ifu_rsp_instr, pc: pcq[rptr], err: ifu_rsp_err,
                    rv32: (ifu_rsp_instr[1:0] == 2'b11)};

`ifdef E203_IFU_RSP2IR_BYPASS_EN
  logic byp;
  assign byp    = ~ir_valid_r & ifu_rsp_valid & ~stale & ~pipe_flush;
  // A bypassed response consumed by decode in the same cycle is not kept.
  assign ld_reg = load & (ir_valid_r | ~ir_ready);
  assign ir_valid = ir_valid_r | (ifu_rsp_valid & ~stale & ~pipe_flush);
  assign ir_out   = byp ? rsp_ir : ir_r;
`else
  assign ld_reg   = load;
  assign ir_valid = ir_valid_r;
  assign ir_out   = ir_r;
`endif

  assign ir_instr = ir_out.instr;
  assign ir_pc    = ir_out.pc;
  assign ir_err   = ir_out.err;
  assign ir_rv32  = ir_out.rv32;

  always_ff @(posedge clk) begin
    if (push) pcq[wptr] <= ifu_req_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   out_cnt <= out_cnt + CNT_W'(1);
        2'b01:   out_cnt <= out_cnt - CNT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
      // Every pre-flush request becomes stale; one popping now is already gone.
      if (pipe_flush)      drop_cnt <= out_cnt - CNT_W'(pop);
      else if (pop & stale) drop_cnt <= drop_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_valid_r <= 1'b0;
      ir_r       <= '0;
    end else begin
      if (pipe_flush)                   ir_valid_r <= 1'b0;
      else if (ld_reg)                  ir_valid_r <= 1'b1;
      else if (ir_valid_r & ir_ready)   ir_valid_r <= 1'b0;
      if (ld_reg) ir_r <= rsp_ir;
    end
  end
endmodule

// File: tb/tb_e203_ifu_rsp2ir.sv
// Directed bench for e203_ifu_rsp2ir: expected IR entries go into a scoreboard
// queue at stimulus time; a negedge monitor pops one per IR handshake.
`ifndef E203_PC_SIZE
`define E203_PC_SIZE 32
`endif

module tb_e203_ifu_rsp2ir;
  localparam int PCW = `E203_PC_SIZE;
`ifdef E203_IFU_RSP2IR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0]    instr;
    logic [PCW-1:0] pc;
    logic           err;
    logic           rv32;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ifu_req_valid, ifu_req_ready;
  logic [PCW-1:0] ifu_req_pc;
  logic           req_allow;
  logic           ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [31:0]    ifu_rsp_instr;
  logic           pipe_flush;
  logic           ir_valid, ir_ready;
  logic [31:0]    ir_instr;
  logic [PCW-1:0] ir_pc;
  logic           ir_err, ir_rv32;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  e203_ifu_rsp2ir #(.OUTS_DEPTH(2), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_pc(ifu_req_pc), .req_allow(req_allow),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_err(ifu_rsp_err), .ifu_rsp_instr(ifu_rsp_instr),
    .pipe_flush(pipe_flush),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_instr(ir_instr),
    .ir_pc(ir_pc), .ir_err(ir_err), .ir_rv32(ir_rv32)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic req(input logic [PCW-1:0] pc);
    ifu_req_valid = 1'b1; ifu_req_ready = 1'b1; ifu_req_pc = pc;
    step();
    ifu_req_valid = 1'b0;
  endtask

  task automatic rsp(input logic [31:0] instr, input logic err, input bit keep,
                     input logic [PCW-1:0] pc, input logic rv32);
    ifu_rsp_valid = 1'b1; ifu_rsp_instr = instr; ifu_rsp_err = err;
    if (keep) exp_q.push_back('{instr, pc, err, rv32});
    @(negedge clk);
    chk("rsp_ready", ifu_rsp_ready, 1);
    step();
    ifu_rsp_valid = 1'b0;
  endtask

  task automatic flush_pulse();
    pipe_flush = 1'b1;
    step();
    pipe_flush = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && ir_valid && ir_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL ir_unexpected act_pc=%0h act_instr=%0h exp=none", ir_pc, ir_instr);
      end else begin
        mon_e = exp_q.pop_front();
        if (ir_instr !== mon_e.instr || ir_pc !== mon_e.pc ||
            ir_err !== mon_e.err || ir_rv32 !== mon_e.rv32) begin
          failures++;
          $display("FAIL ir_data act=%0h/%0h/%0b/%0b exp=%0h/%0h/%0b/%0b",
                   ir_instr, ir_pc, ir_err, ir_rv32,
                   mon_e.instr, mon_e.pc, mon_e.err, mon_e.rv32);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; ifu_req_valid = 0; ifu_req_ready = 0; ifu_req_pc = '0;
    ifu_rsp_valid = 0; ifu_rsp_err = 0; ifu_rsp_instr = '0;
    pipe_flush = 0; ir_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_req_allow", req_allow, 1);
    chk("rst_rsp_ready", ifu_rsp_ready, 1);
    chk("rst_ir_pc", ir_pc, 0);
    chk("rst_ir_instr", ir_instr, 0);
    chk("rst_ir_flags", {ir_err, ir_rv32}, 0);
    rst_n = 1'b1;
    step();

    // Basic fetch and latency
    req(32'h8000_0000);
    chk("one_out_allow", req_allow, 1);
    ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'h0000_0513; ifu_rsp_err = 1'b0;
    exp_q.push_back('{32'h0000_0513, 32'h8000_0000, 1'b0, 1'b1});
    @(negedge clk);
    chk("lat_rsp_cycle_valid", ir_valid, BYP);
    step();
    ifu_rsp_valid = 1'b0;
    @(negedge clk);
    chk("lat_next_cycle_valid", ir_valid, !BYP);
    chk("empty_allow", req_allow, 1);
    step();

    // Back-pressure and ordering
    req(32'h100); req(32'h104);
    ir_ready = 1'b0;
    rsp(32'h0000_0013, 1'b0, 1'b1, 32'h100, 1'b1);
    ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'h0010_0093;
    @(negedge clk);
    chk("bp_rsp_ready", ifu_rsp_ready, 0);
    chk("bp_ir_valid", ir_valid, 1);
    chk("bp_ir_pc", ir_pc, 32'h100);
    step();
    @(negedge clk);
    chk("bp_hold_instr", ir_instr, 32'h0000_0013);
    step();
    ir_ready = 1'b1;
    exp_q.push_back('{32'h0010_0093, 32'h104, 1'b0, 1'b1});
    @(negedge clk);
    chk("bp_release_ready", ifu_rsp_ready, 1);
    step();
    ifu_rsp_valid = 1'b0;
    step();

    // Full queue, simultaneous push/pop, pointer wrap
    req(32'h300); req(32'h304);
    @(negedge clk);
    chk("full_allow", req_allow, 0);
    step();
    ifu_req_valid = 1'b1; ifu_req_ready = 1'b1; ifu_req_pc = 32'h308;
    ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'h0030_0113; ifu_rsp_err = 1'b0;
    exp_q.push_back('{32'h0030_0113, 32'h300, 1'b0, 1'b1});
    @(negedge clk);
    chk("pushpop_rsp_ready", ifu_rsp_ready, 1);
    step();
    ifu_req_valid = 1'b0; ifu_rsp_valid = 1'b0;
    @(negedge clk);
    chk("pushpop_still_full", req_allow, 0);
    step();
    rsp(32'h0030_4113, 1'b0, 1'b1, 32'h304, 1'b1);
    rsp(32'h0030_8113, 1'b0, 1'b1, 32'h308, 1'b1);
    @(negedge clk);
    chk("drained_allow", req_allow, 1);
    step();

    // Flush with two outstanding, then a post-flush request
    req(32'h400); req(32'h404);
    flush_pulse();
    rsp(32'h0BAD_0013, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("drop1_ir_valid", ir_valid, 0);
    step();
    req(32'h200);
    rsp(32'h0BAD_1013, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("drop2_ir_valid", ir_valid, 0);
    step();
    rsp(32'h0020_0113, 1'b0, 1'b1, 32'h200, 1'b1);
    step();

    // Flush coinciding with a response
    req(32'h500); req(32'h504);
    pipe_flush = 1'b1; ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'h0BAD_2013;
    @(negedge clk);
    chk("flushrsp_ready", ifu_rsp_ready, 1);
    chk("flushrsp_ir_valid", ir_valid, 0);
    step();
    pipe_flush = 1'b0; ifu_rsp_valid = 1'b0;
    @(negedge clk);
    chk("flushrsp_next_valid", ir_valid, 0);
    step();
    rsp(32'h0BAD_3013, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("flushrsp_drop_valid", ir_valid, 0);
    step();
    req(32'h600);
    rsp(32'h0060_0113, 1'b0, 1'b1, 32'h600, 1'b1);
    step();

    // Flush clears a held IR
    ir_ready = 1'b0;
    req(32'h700);
    rsp(32'h0070_0113, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("held_ir_valid", ir_valid, 1);
    step();
    flush_pulse();
    @(negedge clk);
    chk("flush_clears_ir", ir_valid, 0);
    step();
    ir_ready = 1'b1;

    // Error response, 16-bit encoding
    req(32'h800);
    rsp(32'h0000_0001, 1'b1, 1'b1, 32'h800, 1'b0);
    step();

    // Reset mid-transfer leaves no residue
    req(32'h900);
    rst_n = 1'b0;
    #2;
    chk("rst_mid_allow", req_allow, 1);
    chk("rst_mid_ir_valid", ir_valid, 0);
    step();
    rst_n = 1'b1;
    step();
    req(32'hA00);
    rsp(32'h00A0_0113, 1'b0, 1'b1, 32'hA00, 1'b1);
    repeat (3) step();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/e203_ifu_rsp2ir.md
Name: e203_ifu_rsp2ir

Overview:
- IFU instruction-register stage directly downstream of the fetch-to-ICB bridge. It consumes `ifu_rsp_*` and produces the registered IR/PC handed to EXU decode.
- Responses carry no PC, so the block snoops request handshakes and keeps an in-order queue of outstanding PCs.
- On flush (branch/trap redirect) it discards responses belonging to pre-flush requests and never presents them downstream.

Parameters:
- OUTS_DEPTH, 2, max outstanding fetch requests / PC-queue entries; legal 1..4.
- CNT_W, 3, width of the outstanding and drop counters; must satisfy 2^CNT_W > OUTS_DEPTH.

Ports:
- clk  in  1  core clock
- rst_n  in  1  async active-low reset
- ifu_req_valid  in  1  snooped fetch request valid
- ifu_req_ready  in  1  snooped fetch request ready; push when both high
- ifu_req_pc  in  `E203_PC_SIZE  PC of the snooped request
- req_allow  out  1  upstream may issue a new request (PC queue not full)
- ifu_rsp_valid  in  1  fetch response valid
- ifu_rsp_ready  out  1  response accept
- ifu_rsp_err  in  1  bus/ITCM error on fetch
- ifu_rsp_instr  in  32  fetched instruction word
- pipe_flush  in  1  one-cycle redirect pulse; all outstanding requests become stale
- ir_valid  out  1  IR holds a valid instruction
- ir_ready  in  1  decode accepts IR
- ir_instr  out  32  instruction
- ir_pc  out  `E203_PC_SIZE  PC of ir_instr
- ir_err  out  1  fetch error flag
- ir_rv32  out  1  ir_instr[1:0]==2'b11

Behaviour:
- Reset (async, rst_n low) clears:
  - PC queue pointers, out_cnt and drop_cnt to 0.
  - ir_valid, ir_err and ir_rv32 to 0; ir_instr and ir_pc to 0.
- Resulting output values after reset: req_allow=1, ifu_rsp_ready=1. Reset mid-transfer abandons everything in flight with no residual state.
- Event definitions:
  - req_fire = ifu_req_valid & ifu_req_ready.
  - rsp_fire = ifu_rsp_valid & ifu_rsp_ready.
  - ir_fire = ir_valid & ir_ready.
- PC queue: circular FIFO of OUTS_DEPTH entries.
  - req_fire pushes ifu_req_pc; rsp_fire pops the head.
  - Pointers wrap modulo OUTS_DEPTH.
  - out_cnt += req_fire - rsp_fire; simultaneous push and pop leave the count unchanged, including when full.
- req_allow = (out_cnt != OUTS_DEPTH). A push while full is a protocol violation: ignored, count saturates.
- rsp_fire with out_cnt==0 is a protocol violation: no pop, no IR load.
- Stale tracking:
  - A response is stale when drop_cnt != 0.
  - A stale rsp_fire decrements drop_cnt and pops the queue; IR is unaffected.
- ifu_rsp_ready = (drop_cnt != 0) | ~ir_valid | ir_ready | pipe_flush.
- IR load: non-stale rsp_fire with no flush in the same cycle loads IR on the next edge, i.e. one-cycle latency from response to ir_valid.
  - ir_pc = queue head.
  - ir_instr = ifu_rsp_instr.
  - ir_err = ifu_rsp_err.
  - ir_rv32 = ifu_rsp_instr[1:0]==2'b11.
- ir_valid clears on ir_fire without a new load; load and ir_fire in the same cycle keep ir_valid=1 with the new contents.
- IR contents are held stable while ir_valid & ~ir_ready.
- pipe_flush:
  - ir_valid cleared next cycle.
  - drop_cnt_nxt = out_cnt - rsp_fire. All pre-flush outstanding requests are counted; a response firing in the flush cycle is itself dropped.
  - A req_fire in the flush cycle is post-flush: it is pushed and not counted in drop_cnt.
  - A flush while drop_cnt != 0 overwrites drop_cnt with the formula above, which subsumes the old stale entries.
- Error responses are forwarded like normal instructions; no special state is kept.

Optional Feature:
- Macro: E203_IFU_RSP2IR_BYPASS_EN.
- Defined: when ~ir_valid and the response is non-stale, rsp_fire drives ir_* combinationally in the same cycle (zero latency).
  - The response is registered only if ~ir_ready.
  - ir_valid output = ir_valid_r | (ifu_rsp_valid & drop_cnt==0 & ~pipe_flush).
- Undefined: all ir_* come from registers; one-cycle latency as specified above.

Test Plan:
- Reset then push PC 0x8000_0000; respond with instr 0x0000_0513 err=0 -> next cycle ir_valid=1, ir_pc=0x8000_0000, ir_rv32=1, out_cnt=0.
- Two requests (0x100, 0x104) and two responses with ir_ready=0 -> first response lands in IR; ifu_rsp_ready=0 until ir_ready=1; second IR has pc 0x104. Order is preserved.
- OUTS_DEPTH=2: two pushes with no response -> req_allow=0; push and pop in the same cycle -> out_cnt stays 2 and head wraps correctly.
- Two outstanding, pipe_flush, then push 0x200 -> next two responses are accepted and dropped (ir_valid stays 0); third response yields ir_pc=0x200.
- pipe_flush coinciding with rsp_fire and out_cnt=2 -> drop_cnt=1, the coinciding response is dropped and ir_valid=0.
- Response with err=1, instr 0x0000_0001 -> ir_err=1, ir_rv32=0. With BYPASS_EN and IR empty: ir_valid=1 in the same cycle as rsp_fire.
